// File: rtl/fmc_raster_reader_if.sv
// fmc_raster_reader_if: control, frame memory and pixel stream signals of the raster reader
interface fmc_raster_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 16
);
  logic                  START;
  logic                  BUSY;
  logic                  DONE;
  logic                  FM_CSN;
  logic                  FM_WEN;
  logic [ADDR_WIDTH-1:0] FM_ADDR;
  logic [DATA_WIDTH-1:0] FM_DOUT;
  logic                  PIX_VALID;
  logic                  PIX_READY;
  logic [23:0]           PIX_DATA;
  logic                  PIX_SOF;
  logic                  PIX_EOL;
  modport master (
    input  START, FM_DOUT, PIX_READY,
    output BUSY, DONE, FM_CSN, FM_WEN, FM_ADDR, PIX_VALID, PIX_DATA, PIX_SOF, PIX_EOL
  );
  modport slave (
    output START, FM_DOUT, PIX_READY,
    input  BUSY, DONE, FM_CSN, FM_WEN, FM_ADDR, PIX_VALID, PIX_DATA, PIX_SOF, PIX_EOL
  );
endinterface

// File: rtl/fmc_raster_reader.sv
// fmc_raster_reader: reads 2x2 pixel quads once each and emits a raster-order pixel stream
module fmc_raster_reader #(
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 16
) (
  input logic                 CLK,
  input logic                 RSTN,
  fmc_raster_reader_if.master bus
);
  localparam int WCW = HRES > 2 ? $clog2(HRES / 2) : 1;
  localparam int WRW = VRES > 2 ? $clog2(VRES / 2) : 1;
  localparam logic [WCW-1:0]        WC_LAST   = WCW'(HRES / 2 - 1);
  localparam logic [WRW-1:0]        WR_LAST   = WRW'(VRES / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_WORDS = ADDR_WIDTH'(HRES / 2);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_REQ = 3'd1;
  localparam logic [2:0] RD_CAP = 3'd2;
  localparam logic [2:0] TOP0   = 3'd3;
  localparam logic [2:0] TOP1   = 3'd4;
  localparam logic [2:0] BOT0   = 3'd5;
  localparam logic [2:0] BOT1   = 3'd6;
  localparam logic [2:0] FIN    = 3'd7;
  logic [2:0]     state;
  logic [WRW-1:0] wr;
  logic [WCW-1:0] wc;
  logic [47:0]    word;
  logic [47:0]    lb [HRES/2];
  logic           hs;
  assign hs            = bus.PIX_VALID & bus.PIX_READY;
  assign bus.BUSY      = state != IDLE;
  assign bus.DONE      = state == FIN;
  assign bus.FM_CSN    = state != RD_REQ;
  assign bus.FM_WEN    = 1'b1;
  assign bus.FM_ADDR   = ADDR_WIDTH'(wr) * ROW_WORDS + ADDR_WIDTH'(wc);
  assign bus.PIX_VALID = state >= TOP0 && state <= BOT1;
  assign bus.PIX_SOF   = state == TOP0 && wr == '0 && wc == '0;
  assign bus.PIX_EOL   = (state == TOP1 || state == BOT1) && wc == WC_LAST;
  assign bus.PIX_DATA  = state == TOP0 ? word[47:24] :
                         state == TOP1 ? word[23:0] :
                         state == BOT0 ? lb[wc][47:24] :
                         state == BOT1 ? lb[wc][23:0] : 24'd0;
  // Scan FSM: one read per quad on the even line, odd line replayed from the line buffer
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state <= IDLE;
      wr    <= '0;
      wc    <= '0;
      word  <= '0;
    end else
      case (state)
        IDLE:   if (bus.START) begin
                  state <= RD_REQ;
                  wr    <= '0;
                  wc    <= '0;
                end
        RD_REQ: state <= RD_CAP;
        RD_CAP: begin
                  word  <= bus.FM_DOUT[DATA_WIDTH-1 -: 48];
                  state <= TOP0;
                end
        TOP0:   if (hs) state <= TOP1;
        TOP1:   if (hs) begin
                  wc    <= wc == WC_LAST ? '0 : wc + 1'b1;
                  state <= wc == WC_LAST ? BOT0 : RD_REQ;
                end
        BOT0:   if (hs) state <= BOT1;
        BOT1:   if (hs) begin
                  wc    <= wc == WC_LAST ? '0 : wc + 1'b1;
                  wr    <= wc == WC_LAST && wr != WR_LAST ? wr + 1'b1 : wr;
                  state <= wc != WC_LAST ? BOT0 : wr == WR_LAST ? FIN : RD_REQ;
                end
        FIN:    state <= IDLE;
      endcase
  // Park the odd-row half of each quad for the following output line
  always_ff @(posedge CLK)
    if (state == RD_CAP) lb[wc] <= bus.FM_DOUT[DATA_WIDTH-49 -: 48];
endmodule
